// File: rtl/branch_resolve_queue_if.sv
// Bundles the allocate, resolve and predictor write-port signals of the branch resolve queue.
// The master side drives allocations and resolves. The slave side is the queue.
interface branch_resolve_queue_if #(
  parameter int HISTORY_LEN = 8,
  parameter int DEPTH       = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: an alloc transfers on a clock edge where alloc_valid && alloc_ready are both high.
  // A resolve transfers on a clock edge where resolve_valid is high and count != 0.
  // Neither valid waits for ready before it asserts.
  logic                   alloc_valid;
  logic                   alloc_ready;
  logic [HISTORY_LEN-1:0] alloc_pc_bits;
  logic [HISTORY_LEN-1:0] alloc_history;
  logic                   alloc_pred;
  logic                   resolve_valid;
  logic                   resolve_taken;
  logic                   update_en;
  logic [HISTORY_LEN-1:0] pc_bits_write;
  logic [HISTORY_LEN-1:0] history_write;
  logic                   outcome;
  logic                   mispredict;
  logic [CW-1:0]          count;
  logic                   resolve_err;

  modport master (
    output alloc_valid, alloc_pc_bits, alloc_history, alloc_pred,
    output resolve_valid, resolve_taken,
    input  alloc_ready, update_en, pc_bits_write, history_write,
    input  outcome, mispredict, count, resolve_err
  );

  modport slave (
    input  alloc_valid, alloc_pc_bits, alloc_history, alloc_pred,
    input  resolve_valid, resolve_taken,
    output alloc_ready, update_en, pc_bits_write, history_write,
    output outcome, mispredict, count, resolve_err
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order FIFO of predicted branches. It writes each resolved branch back to the gshare predictor.
// A mispredict flushes every younger in-flight record.
module branch_resolve_queue #(
  parameter int HISTORY_LEN = 8,
  parameter int DEPTH       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_resolve_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [HISTORY_LEN-1:0] pc_mem   [DEPTH];
  logic [HISTORY_LEN-1:0] hist_mem [DEPTH];
  logic                   pred_mem [DEPTH];

  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count_q;
  logic                   update_q, mis_q, outcome_q, err_q;
  logic [HISTORY_LEN-1:0] pc_q, hist_q;

  logic alloc_fire, resolve_fire, mis_now;

  assign bus.alloc_ready = (count_q != CW'(DEPTH));
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;
  assign resolve_fire    = bus.resolve_valid && (count_q != '0);
  assign mis_now         = resolve_fire && (pred_mem[rd_ptr] != bus.resolve_taken);

  // Storage is never reset. An alloc dropped by a flush writes a slot that the pointers then treat as free.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_mem[wr_ptr]   <= bus.alloc_pc_bits;
      hist_mem[wr_ptr] <= bus.alloc_history;
      pred_mem[wr_ptr] <= bus.alloc_pred;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      update_q  <= 1'b0;
      mis_q     <= 1'b0;
      outcome_q <= 1'b0;
      err_q     <= 1'b0;
      pc_q      <= '0;
      hist_q    <= '0;
    end else begin
      update_q <= resolve_fire;
      mis_q    <= mis_now;
      if (bus.resolve_valid && (count_q == '0))
        err_q <= 1'b1;
      if (resolve_fire) begin
        pc_q      <= pc_mem[rd_ptr];
        hist_q    <= hist_mem[rd_ptr];
        outcome_q <= bus.resolve_taken;
        rd_ptr    <= rd_ptr + 1'b1;
      end
      if (mis_now) begin
        // A flush empties the queue behind the branch that mispredicted, including any alloc in the same cycle.
        wr_ptr  <= rd_ptr + 1'b1;
        count_q <= '0;
      end else begin
        if (alloc_fire)
          wr_ptr <= wr_ptr + 1'b1;
        if (alloc_fire && !resolve_fire)
          count_q <= count_q + 1'b1;
        else if (resolve_fire && !alloc_fire)
          count_q <= count_q - 1'b1;
      end
    end
  end

  assign bus.update_en     = update_q;
  assign bus.mispredict    = mis_q;
  assign bus.outcome       = outcome_q;
  assign bus.pc_bits_write = pc_q;
  assign bus.history_write = hist_q;
  assign bus.count         = count_q;
  assign bus.resolve_err   = err_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed testbench for branch_resolve_queue with DEPTH=4 and HISTORY_LEN=8.
// Expected values are written by hand from the queue's intended behaviour.
module tb_branch_resolve_queue;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  branch_resolve_queue_if #(.HISTORY_LEN(8), .DEPTH(4)) bus ();

  branch_resolve_queue #(.HISTORY_LEN(8), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_valid   = 1'b0;
    bus.alloc_pc_bits = '0;
    bus.alloc_history = '0;
    bus.alloc_pred    = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;
  endtask

  task automatic set_alloc(input logic [7:0] pc, input logic [7:0] h, input logic p);
    bus.alloc_valid   = 1'b1;
    bus.alloc_pc_bits = pc;
    bus.alloc_history = h;
    bus.alloc_pred    = p;
  endtask

  task automatic alloc(input logic [7:0] pc, input logic [7:0] h, input logic p);
    set_alloc(pc, h, p);
    step();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic resolve(input logic t);
    bus.resolve_valid = 1'b1;
    bus.resolve_taken = t;
    step();
    bus.resolve_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_upd"},  32'(bus.update_en), 0);
    chk({tag, "_mis"},  32'(bus.mispredict), 0);
    chk({tag, "_pc"},   32'(bus.pc_bits_write), 0);
    chk({tag, "_hist"}, 32'(bus.history_write), 0);
    chk({tag, "_out"},  32'(bus.outcome), 0);
    chk({tag, "_cnt"},  32'(bus.count), 0);
    chk({tag, "_err"},  32'(bus.resolve_err), 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle_inputs();
    reset = 1'b0;
    #2;
    chk_all_zero("por");
    #10;
    reset = 1'b1;
    step();
    chk("por_ready", 32'(bus.alloc_ready), 1);

    // Test 1: apply reset mid-stream with 3 entries and an update pulse high.
    alloc(8'h01, 8'h11, 1'b1);
    alloc(8'h02, 8'h12, 1'b0);
    alloc(8'h03, 8'h13, 1'b1);
    set_alloc(8'h04, 8'h14, 1'b0);
    bus.resolve_valid = 1'b1;
    bus.resolve_taken = 1'b1;
    step();
    idle_inputs();
    chk("t1_pre_upd", 32'(bus.update_en), 1);
    chk("t1_pre_pc",  32'(bus.pc_bits_write), 32'h01);
    chk("t1_pre_cnt", 32'(bus.count), 3);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("t1_async");
    #3;
    reset = 1'b1;
    step();
    chk("t1_ready", 32'(bus.alloc_ready), 1);
    chk("t1_cnt",   32'(bus.count), 0);

    // Test 2: one alloc, then a correctly predicted resolve two cycles later.
    alloc(8'h3C, 8'hA5, 1'b1);
    step();
    resolve(1'b1);
    chk("t2_upd",  32'(bus.update_en), 1);
    chk("t2_pc",   32'(bus.pc_bits_write), 32'h3C);
    chk("t2_hist", 32'(bus.history_write), 32'hA5);
    chk("t2_out",  32'(bus.outcome), 1);
    chk("t2_mis",  32'(bus.mispredict), 0);
    chk("t2_cnt",  32'(bus.count), 0);
    step();
    chk("t2_pulse",   32'(bus.update_en), 0);
    chk("t2_hold_pc", 32'(bus.pc_bits_write), 32'h3C);

    // Test 3: fill the queue, try a 5th alloc, then drain and refill across the pointer wrap.
    do_reset();
    for (int i = 0; i < 4; i++) alloc(8'h10 + 8'(i), 8'h80 + 8'(i), i[0]);
    chk("t3_full_cnt",   32'(bus.count), 4);
    chk("t3_full_ready", 32'(bus.alloc_ready), 0);
    alloc(8'hFF, 8'hFF, 1'b1);
    chk("t3_5th_cnt", 32'(bus.count), 4);
    for (int i = 0; i < 4; i++) begin
      resolve(i[0]);
      chk($sformatf("t3_upd%0d", i),  32'(bus.update_en), 1);
      chk($sformatf("t3_pc%0d", i),   32'(bus.pc_bits_write), 32'h10 + i);
      chk($sformatf("t3_hist%0d", i), 32'(bus.history_write), 32'h80 + i);
      chk($sformatf("t3_mis%0d", i),  32'(bus.mispredict), 0);
    end
    chk("t3_empty", 32'(bus.count), 0);
    for (int i = 0; i < 4; i++) alloc(8'h20 + 8'(i), 8'h90 + 8'(i), 1'b0);
    chk("t3_refill_cnt", 32'(bus.count), 4);
    for (int i = 0; i < 4; i++) begin
      resolve(1'b0);
      chk($sformatf("t3_wpc%0d", i), 32'(bus.pc_bits_write), 32'h20 + i);
    end
    chk("t3_wrap_empty", 32'(bus.count), 0);

    // Test 4: a mispredict flushes the queue and drops an alloc in the same cycle.
    do_reset();
    alloc(8'h40, 8'hC0, 1'b1);
    alloc(8'h41, 8'hC1, 1'b0);
    alloc(8'h42, 8'hC2, 1'b1);
    set_alloc(8'h43, 8'hC3, 1'b0);
    bus.resolve_valid = 1'b1;
    bus.resolve_taken = 1'b0;
    step();
    idle_inputs();
    chk("t4_mis", 32'(bus.mispredict), 1);
    chk("t4_out", 32'(bus.outcome), 0);
    chk("t4_upd", 32'(bus.update_en), 1);
    chk("t4_pc",  32'(bus.pc_bits_write), 32'h40);
    chk("t4_cnt", 32'(bus.count), 0);
    resolve(1'b0);
    chk("t4_no_upd",    32'(bus.update_en), 0);
    chk("t4_mis_pulse", 32'(bus.mispredict), 0);
    chk("t4_err",       32'(bus.resolve_err), 1);
    chk("t4_cnt2",      32'(bus.count), 0);

    // Test 5: alloc and correct resolve in the same cycle with 2 entries.
    do_reset();
    alloc(8'h50, 8'hD0, 1'b0);
    alloc(8'h51, 8'hD1, 1'b1);
    set_alloc(8'h52, 8'hD2, 1'b1);
    bus.resolve_valid = 1'b1;
    bus.resolve_taken = 1'b0;
    step();
    idle_inputs();
    chk("t5_cnt", 32'(bus.count), 2);
    chk("t5_upd", 32'(bus.update_en), 1);
    chk("t5_pc",  32'(bus.pc_bits_write), 32'h50);
    chk("t5_mis", 32'(bus.mispredict), 0);
    step();
    chk("t5_pulse", 32'(bus.update_en), 0);
    resolve(1'b1);
    chk("t5_pc1",   32'(bus.pc_bits_write), 32'h51);
    chk("t5_hist1", 32'(bus.history_write), 32'hD1);
    chk("t5_mis1",  32'(bus.mispredict), 0);
    resolve(1'b1);
    chk("t5_pc2",   32'(bus.pc_bits_write), 32'h52);
    chk("t5_hist2", 32'(bus.history_write), 32'hD2);
    chk("t5_cnt2",  32'(bus.count), 0);

    // Test 6: a resolve on an empty queue sets a sticky error.
    do_reset();
    resolve(1'b1);
    chk("t6_no_upd", 32'(bus.update_en), 0);
    chk("t6_err",    32'(bus.resolve_err), 1);
    alloc(8'h60, 8'hE0, 1'b1);
    resolve(1'b1);
    chk("t6_upd",  32'(bus.update_en), 1);
    chk("t6_err2", 32'(bus.resolve_err), 1);
    step();
    chk("t6_err3", 32'(bus.resolve_err), 1);
    reset = 1'b0;
    #1;
    chk("t6_err_rst", 32'(bus.resolve_err), 0);
    #3;
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
